// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state type and baud-rate helpers
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  localparam int CLK_HZ = 12000000;
  localparam int BAUD = 115200;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop line synchronizer plus 3-sample majority vote, idle-high reset
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s,
  output logic vote
);
  logic meta;
  logic [2:0] hist;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      hist <= '1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      hist <= {hist[1:0], rx_s};
    end
  assign vote = (hist[0] & hist[1]) | (hist[1] & hist[2]) | (hist[0] & hist[2]);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit vote, stop check and one-deep valid/ack holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_n_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_dat_o,
  output logic       uart_valid_o,
  input  logic       uart_ack_i,
  output logic       uart_busy_o,
  output logic       uart_frame_err_o,
  output logic       uart_overrun_o
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(HALF);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic rx_s, vote, deliver, ferr;
  uart_rx_sync u_sync (
    .clk  (sys_clk_i),
    .rst_n(sys_rst_n_i),
    .rx   (uart_rx_i),
    .rx_s (rx_s),
    .vote (vote)
  );
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i)
    if (!sys_rst_n_i) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      uart_dat_o <= '0;
      uart_valid_o <= 1'b0;
      uart_frame_err_o <= 1'b0;
      uart_overrun_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      uart_frame_err_o <= ferr;
      uart_overrun_o <= deliver && uart_valid_o && !uart_ack_i;
      uart_valid_o <= deliver || (uart_valid_o && !uart_ack_i);
      if (deliver && (!uart_valid_o || uart_ack_i)) uart_dat_o <= sh;
    end
  always_comb begin
    state_n = state;
    cnt_n = (cnt == LAST) ? '0 : cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    deliver = 1'b0;
    ferr = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : START;
      end
      START:
        if (cnt == MID && vote) state_n = IDLE;
        else if (cnt == LAST) begin
          state_n = DATA;
          idx_n = '0;
        end
      DATA: begin
        if (cnt == MID) sh_n = {vote, sh[7:1]};
        if (cnt == LAST) begin
          idx_n = idx + 3'd1;
          state_n = (idx == 3'd7) ? STOP : DATA;
        end
      end
      STOP:
        if (cnt == MID) begin
          deliver = vote;
          ferr = !vote;
          state_n = vote ? IDLE : BREAK;
        end
      BREAK: begin
        cnt_n = '0;
        state_n = rx_s ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
  assign uart_busy_o = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a byte-level reference model
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int BT = CPB * 100;
  localparam int LAT = 3 + 9 * CPB + CPB / 2 + 1;
  logic clk = 1'b0;
  logic rst_n, line, man_ack, ack, valid, busy, ferr, ovr;
  logic auto_ack = 1'b0;
  logic valid_q = 1'b0;
  logic [7:0] dat;
  logic [7:0] rx_q[$];
  int total = 0, bad = 0, cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int n_rise = 0, n_ferr = 0, n_ovr = 0, wcnt = 0;
  int ack_dly = -1;
  always #50 clk = ~clk;
  assign ack = auto_ack | man_ack;
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .sys_clk_i       (clk),
    .sys_rst_n_i     (rst_n),
    .uart_rx_i       (line),
    .uart_dat_o      (dat),
    .uart_valid_o    (valid),
    .uart_ack_i      (ack),
    .uart_busy_o     (busy),
    .uart_frame_err_o(ferr),
    .uart_overrun_o  (ovr)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    valid_q <= valid;
    if (valid && !valid_q) begin
      n_rise <= n_rise + 1;
      rise_cyc <= cyc;
    end
    if (ferr) n_ferr <= n_ferr + 1;
    if (ovr) n_ovr <= n_ovr + 1;
    if (ack_dly >= 0 && valid && !auto_ack) begin
      if (wcnt >= ack_dly) begin
        auto_ack <= 1'b1;
        rx_q.push_back(dat);
        wcnt <= 0;
      end else wcnt <= wcnt + 1;
    end else begin
      auto_ack <= 1'b0;
      wcnt <= 0;
    end
  end
  task automatic send_byte(input logic [7:0] b, input int bt, input logic stop);
    fall_cyc = cyc;
    line = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      line = b[i];
      #(bt);
    end
    line = stop;
    #(bt);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    line = 1'b1;
    man_ack = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (dat !== 8'h00) begin bad++; $display("FAIL reset_dat got=%h exp=00", dat); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (ferr !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    total++; if (ovr !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", ovr); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask
  task automatic test_basic;
    int r0, f0, o0, q0, lat;
    ack_dly = 2;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr; q0 = rx_q.size();
    @(negedge clk);
    send_byte(8'h55, BT, 1'b1);
    repeat (6) @(negedge clk);
    lat = rise_cyc - fall_cyc;
    total++; if (rx_q.size() != q0 + 1) begin bad++; $display("FAIL basic_count got=%0d exp=%0d", rx_q.size() - q0, 1); end
    else begin
      total++; if (rx_q[q0] !== 8'h55) begin bad++; $display("FAIL basic_dat got=%h exp=55", rx_q[q0]); end
    end
    total++; if (n_rise - r0 != 1) begin bad++; $display("FAIL basic_rises got=%0d exp=1", n_rise - r0); end
    total++; if (n_ferr != f0 || n_ovr != o0) begin bad++; $display("FAIL basic_pulses got=ferr%0d/ovr%0d exp=0/0", n_ferr - f0, n_ovr - o0); end
    total++; if (lat < LAT - 1 || lat > LAT + 1) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (busy !== 1'b0 || valid !== 1'b0) begin bad++; $display("FAIL basic_after got=busy%b/valid%b exp=0/0", busy, valid); end
  endtask
  task automatic test_back_to_back;
    int rates[3] = '{BT, BT * 97 / 100, BT * 103 / 100};
    int q0;
    ack_dly = 0;
    foreach (rates[k]) begin
      q0 = rx_q.size();
      @(negedge clk);
      send_byte(8'hA3, rates[k], 1'b1);
      send_byte(8'h0F, rates[k], 1'b1);
      repeat (8) @(negedge clk);
      total++; if (rx_q.size() != q0 + 2) begin bad++; $display("FAIL b2b_count bt=%0d got=%0d exp=2", rates[k], rx_q.size() - q0); end
      else begin
        total++; if (rx_q[q0] !== 8'hA3) begin bad++; $display("FAIL b2b_first bt=%0d got=%h exp=a3", rates[k], rx_q[q0]); end
        total++; if (rx_q[q0+1] !== 8'h0F) begin bad++; $display("FAIL b2b_second bt=%0d got=%h exp=0f", rates[k], rx_q[q0+1]); end
      end
    end
  endtask
  task automatic test_random;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int q0, f0, o0;
    ack_dly = int'($urandom_range(0, 3));
    q0 = rx_q.size(); f0 = n_ferr; o0 = n_ovr;
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, int'($urandom_range(BT * 97 / 100, BT * 103 / 100)), 1'b1);
    end
    repeat (8) @(negedge clk);
    total++; if (rx_q.size() != q0 + exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", rx_q.size() - q0, exp_q.size()); end
    else foreach (exp_q[i]) begin
      total++; if (rx_q[q0+i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d got=%h exp=%h", i, rx_q[q0+i], exp_q[i]); end
    end
    total++; if (n_ferr != f0 || n_ovr != o0) begin bad++; $display("FAIL rand_pulses got=ferr%0d/ovr%0d exp=0/0", n_ferr - f0, n_ovr - o0); end
  endtask
  task automatic test_overrun;
    int r0, o0;
    ack_dly = -1;
    r0 = n_rise; o0 = n_ovr;
    @(negedge clk);
    send_byte(8'h11, BT, 1'b1);
    repeat (6) @(negedge clk);
    total++; if (valid !== 1'b1 || dat !== 8'h11) begin bad++; $display("FAIL ovr_first got=%b/%h exp=1/11", valid, dat); end
    @(negedge clk);
    send_byte(8'h22, BT, 1'b1);
    repeat (6) @(negedge clk);
    total++; if (valid !== 1'b1 || dat !== 8'h11) begin bad++; $display("FAIL ovr_keep got=%b/%h exp=1/11", valid, dat); end
    total++; if (n_ovr - o0 != 1) begin bad++; $display("FAIL ovr_pulse got=%0d exp=1", n_ovr - o0); end
    total++; if (n_rise - r0 != 1) begin bad++; $display("FAIL ovr_rises got=%0d exp=1", n_rise - r0); end
    r0 = n_rise; o0 = n_ovr;
    @(negedge clk);
    fork
      send_byte(8'h22, BT, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    total++; if (valid !== 1'b1 || dat !== 8'h22) begin bad++; $display("FAIL ackswap_dat got=%b/%h exp=1/22", valid, dat); end
    total++; if (n_ovr != o0) begin bad++; $display("FAIL ackswap_ovr got=%0d exp=0", n_ovr - o0); end
    total++; if (n_rise != r0) begin bad++; $display("FAIL ackswap_valid_drop got=%0d exp=0", n_rise - r0); end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL ack_clear got=%b exp=0", valid); end
  endtask
  task automatic test_frame_err;
    int r0, f0, q0;
    ack_dly = 0;
    r0 = n_rise; f0 = n_ferr; q0 = rx_q.size();
    @(negedge clk);
    send_byte(8'h80, BT, 1'b0);
    repeat (20 * CPB) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_mid got=%b exp=1", busy); end
    repeat (20 * CPB) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL break_busy_end got=%b exp=1", busy); end
    total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL ferr_pulse got=%0d exp=1", n_ferr - f0); end
    total++; if (n_rise != r0) begin bad++; $display("FAIL ferr_novalid got=%0d exp=0", n_rise - r0); end
    line = 1'b1;
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL break_exit got=%b exp=0", busy); end
    @(negedge clk);
    send_byte(8'h5A, BT, 1'b1);
    repeat (8) @(negedge clk);
    total++; if (rx_q.size() != q0 + 1) begin bad++; $display("FAIL after_break_count got=%0d exp=1", rx_q.size() - q0); end
    else begin
      total++; if (rx_q[q0] !== 8'h5A) begin bad++; $display("FAIL after_break_dat got=%h exp=5a", rx_q[q0]); end
    end
    total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL after_break_ferr got=%0d exp=1", n_ferr - f0); end
  endtask
  task automatic test_glitch;
    int gw[2] = '{1, 5};
    int r0, f0, g;
    ack_dly = 0;
    foreach (gw[k]) begin
      r0 = n_rise; f0 = n_ferr;
      @(negedge clk);
      g = cyc;
      line = 1'b0;
      repeat (gw[k]) @(negedge clk);
      line = 1'b1;
      while (cyc < g + 4) @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL glitch%0d_start got=%b exp=1", gw[k], busy); end
      repeat (2 * CPB) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch%0d_reject got=%b exp=0", gw[k], busy); end
      total++; if (n_rise != r0 || n_ferr != f0) begin bad++; $display("FAIL glitch%0d_quiet got=rise%0d/ferr%0d exp=0/0", gw[k], n_rise - r0, n_ferr - f0); end
    end
  endtask
  task automatic test_reset_mid;
    int r0, q0;
    ack_dly = 0;
    r0 = n_rise; q0 = rx_q.size();
    @(negedge clk);
    fork
      send_byte(8'hFF, BT, 1'b1);
      begin
        repeat (5 * CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if ({busy, valid, ferr, ovr} !== 4'b0 || dat !== 8'h00) begin bad++; $display("FAIL midreset_outs got=%b%b%b%b/%h exp=0000/00", busy, valid, ferr, ovr, dat); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    total++; if (n_rise != r0 || busy !== 1'b0) begin bad++; $display("FAIL midreset_discard got=rise%0d/busy%b exp=0/0", n_rise - r0, busy); end
    @(negedge clk);
    send_byte(8'h3C, BT, 1'b1);
    repeat (8) @(negedge clk);
    total++; if (rx_q.size() != q0 + 1) begin bad++; $display("FAIL midreset_count got=%0d exp=1", rx_q.size() - q0); end
    else begin
      total++; if (rx_q[q0] !== 8'h3C) begin bad++; $display("FAIL midreset_dat got=%h exp=3c", rx_q[q0]); end
    end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_random;
    test_overrun;
    test_frame_err;
    test_glitch;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
